ssm_y_stream_out: RTL

SSM_Y_STREAM_OUT -- requirements
Module: ssm_y_stream_out

---
 rtl/mamba2_fp16_pkg.sv | 22 ++
 rtl/ssm_y_stream_out.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mamba2_fp16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mamba2_fp16_pkg
// Description : Shared constants for the Mamba-2 FP16 datapath blocks.
//               Holds the FP16 word width and the default batch / head /
//               head-dimension / state-dimension sizes used as parameter
//               defaults by the blocks that import this package.
// Revision    : 1.0 - initial release
// ============================================================================
package mamba2_fp16_pkg;

    // IEEE-754 half-precision word width
    localparam int FP16_W = 16;

    // Default model dimensions
    localparam int DEF_B = 1;   // batch count
    localparam int DEF_H = 4;   // head count
    localparam int DEF_P = 4;   // head dimension
    localparam int DEF_N = 16;  // state dimension

endpackage : mamba2_fp16_pkg
`default_nettype wire

// File: rtl/ssm_y_stream_out.sv
`default_nettype none
// ============================================================================
// Module      : ssm_y_stream_out
// Description : Captures the flat SSM output vector y_flat when the SSM block
//               signals completion and streams it out one FP16 word per
//               valid/ready handshake, lowest index first.
//
// Ports       :
//   clk        in   1           single clock, rising edge
//   rst        in   1           synchronous active-high reset
//   done       in   1           SSM completion flag (level or pulse)
//   y_flat     in   B*H*P*DW    SSM output vector, word i = y_flat[DW*i +: DW]
//   out_data   out  DW          streamed FP16 word
//   out_valid  out  1           out_data valid
//   out_ready  in   1           downstream accept
//   out_last   out  1           high with final word (index B*H*P-1)
//   busy       out  1           a frame is held / streaming
//   overflow   out  1           sticky: a completion arrived mid-frame and
//                               its frame was dropped
//
// Revision    : 1.0 - initial release
// ============================================================================
module ssm_y_stream_out
    import mamba2_fp16_pkg::*;
#(
    parameter int B  = DEF_B,
    parameter int H  = DEF_H,
    parameter int P  = DEF_P,
    parameter int DW = FP16_W
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  done,
    input  wire logic [B*H*P*DW-1:0]   y_flat,
    output logic      [DW-1:0]         out_data,
    output logic                       out_valid,
    input  wire logic                  out_ready,
    output logic                       out_last,
    output logic                       busy,
    output logic                       overflow
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int C_WORDS = B * H * P;
    localparam int C_IDX_W = (C_WORDS > 1) ? $clog2(C_WORDS) : 1;
    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(C_WORDS - 1);

    // State encoding
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [0:0]             r_state;
    logic [C_IDX_W-1:0]     r_index;
    logic [C_WORDS*DW-1:0]  r_frame;
    logic                   r_done_q;
    logic                   r_armed;
    logic                   r_overflow;
    logic [DW-1:0]          r_data;
    logic                   r_last;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                   w_start;
    logic                   w_accept;
    logic                   w_at_last;
    logic [C_IDX_W-1:0]     w_idx_inc;
    logic [DW-1:0]          w_next_word;

    always_comb begin
        // r_armed blocks a "rising edge" that is really just done having been
        // high since before reset released; done must be seen low first.
        w_start     = done & ~r_done_q & r_armed;
        w_accept    = (r_state == S_STREAM) & out_ready;
        w_at_last   = (r_index == C_LAST_IDX);
        // Never step past the last word, so the part-select stays in range
        // even when the word count is not a power of two.
        w_idx_inc   = w_at_last ? '0 : r_index + 1'b1;
        w_next_word = r_frame[DW*w_idx_inc +: DW];
    end

    // ------------------------------------------------------------------------
    // Edge detect, frame capture, index counter and FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_index    <= '0;
            r_frame    <= '0;
            r_done_q   <= 1'b0;
            r_armed    <= ~done;
            r_overflow <= 1'b0;
            r_data     <= '0;
            r_last     <= 1'b0;
        end else begin
            r_done_q <= done;
            r_armed  <= r_armed | ~done;

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_STREAM;
                        r_frame <= y_flat;
                        r_index <= '0;
                        r_data  <= y_flat[DW-1:0];
                        r_last  <= (C_LAST_IDX == '0);
                    end
                end

                S_STREAM: begin
                    if (w_accept && w_at_last) begin
                        if (w_start) begin
                            // Back-to-back frame: the new completion lands
                            // exactly as the old frame drains, so reload
                            // without an idle cycle.
                            r_frame <= y_flat;
                            r_index <= '0;
                            r_data  <= y_flat[DW-1:0];
                            r_last  <= (C_LAST_IDX == '0);
                        end else begin
                            r_state <= S_IDLE;
                            r_index <= '0;
                            r_data  <= '0;
                            r_last  <= 1'b0;
                        end
                    end else begin
                        // A completion while the frame is still draining has
                        // nowhere to go: drop it and flag it.
                        if (w_start) begin
                            r_overflow <= 1'b1;
                        end
                        if (w_accept) begin
                            r_index <= w_idx_inc;
                            r_data  <= w_next_word;
                            r_last  <= (w_idx_inc == C_LAST_IDX);
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_index <= '0;
                    r_data  <= '0;
                    r_last  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign out_data  = r_data;
    assign out_valid = (r_state == S_STREAM);
    assign out_last  = r_last;
    assign busy      = (r_state == S_STREAM);
    assign overflow  = r_overflow;

endmodule : ssm_y_stream_out
`default_nettype wire
